// File: rtl/automata_pkg.sv
// automata_pkg -- shared defaults and scheduler state encoding for the automata display core.
// Revision: 1.0
`default_nettype none

package automata_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 20;
    localparam int DEF_GEN_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GEN        = 2'd1,
        ST_WAIT_FRAME = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/automata_arb2.sv
// automata_arb2 -- two-way write-port arbiter; requester A holds priority out of reset.
// Build option: AUTOMATA_SCHED_RR_EN alternates priority after each conflict. Revision: 1.0
`default_nettype none

module automata_arb2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    logic pri_a_q;
    logic pri_a_d;

    assign gnt_a_o = req_a_i && (!req_b_i || pri_a_q);
    assign gnt_b_o = req_b_i && !gnt_a_o;

    always_comb begin
        pri_a_d = pri_a_q;
`ifdef AUTOMATA_SCHED_RR_EN
        // The winner of a conflict yields priority for the next one.
        if (req_a_i && req_b_i) begin
            pri_a_d = ~pri_a_q;
        end
`else
        pri_a_d = 1'b1;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pri_a_q <= 1'b1;
        end else begin
            pri_a_q <= pri_a_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/automata_sched.sv
// automata_sched -- generation scheduler with double-buffered frame RAM and host/engine write arbitration.
// Build option: AUTOMATA_SCHED_RR_EN (round-robin arbitration in automata_arb2). Revision: 1.0
`default_nettype none

module automata_sched #(
    parameter int ADDR_W = automata_pkg::DEF_ADDR_W,
    parameter int DATA_W = automata_pkg::DEF_DATA_W,
    parameter int GEN_W  = automata_pkg::DEF_GEN_W
) (
    input  logic              clk108,
    input  logic              reset,
    input  logic              frame_done,
    input  logic              run,
    input  logic              step,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              eng_start,
    input  logic              eng_req,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    input  logic              eng_done,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              disp_bank,
    output logic [GEN_W-1:0]  gen_count,
    output logic              busy
);

    import automata_pkg::*;

    localparam logic [1:0] S_IDLE       = ST_IDLE;
    localparam logic [1:0] S_GEN        = ST_GEN;
    localparam logic [1:0] S_WAIT_FRAME = ST_WAIT_FRAME;

    logic [1:0]        state_q,     state_d;
    logic              eng_start_q, eng_start_d;
    logic              disp_bank_q, disp_bank_d;
    logic [GEN_W-1:0]  gen_count_q, gen_count_d;
    logic              ram_we_q,    ram_we_d;
    logic [ADDR_W:0]   ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              eng_req_gated;

    always_comb begin
        state_d     = state_q;
        eng_start_d = 1'b0;
        disp_bank_d = disp_bank_q;
        gen_count_d = gen_count_q;
        case (state_q)
            S_IDLE: begin
                if (run || step) begin
                    state_d     = S_GEN;
                    eng_start_d = 1'b1;
                end
            end
            S_GEN: begin
                // frame_done here is deliberately ignored: the back bank is not yet complete.
                if (eng_done) begin
                    state_d = S_WAIT_FRAME;
                end
            end
            S_WAIT_FRAME: begin
                if (frame_done) begin
                    disp_bank_d = ~disp_bank_q;
                    gen_count_d = gen_count_q + GEN_W'(1);
                    if (run) begin
                        state_d     = S_GEN;
                        eng_start_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The engine may only write while a generation is being computed.
    assign eng_req_gated = eng_req && (state_q == S_GEN);

    automata_arb2 u_arb (
        .clk_i   (clk108),
        .rst_i   (reset),
        .req_a_i (host_req),
        .req_b_i (eng_req_gated),
        .gnt_a_o (host_gnt),
        .gnt_b_o (eng_gnt)
    );

    // Bank select uses the pre-swap disp_bank_q even in the swap cycle.
    always_comb begin
        ram_we_d    = host_gnt || eng_gnt;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (host_gnt) begin
            ram_addr_d  = {disp_bank_q, host_addr};
            ram_wdata_d = host_wdata;
        end else if (eng_gnt) begin
            ram_addr_d  = {~disp_bank_q, eng_addr};
            ram_wdata_d = eng_wdata;
        end
    end

    always_ff @(posedge clk108 or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            eng_start_q <= 1'b0;
            disp_bank_q <= 1'b0;
            gen_count_q <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            eng_start_q <= eng_start_d;
            disp_bank_q <= disp_bank_d;
            gen_count_q <= gen_count_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign eng_start = eng_start_q;
    assign disp_bank = disp_bank_q;
    assign gen_count = gen_count_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_automata_sched.sv
// tb_automata_sched -- directed self-checking bench for automata_sched (default and AUTOMATA_SCHED_RR_EN builds).
// Revision: 1.0
`default_nettype none

module tb_automata_sched;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 20;
    localparam int GEN_W  = 16;
    localparam int GEN_WN = 6;

    logic              clk108;
    logic              reset;
    logic              frame_done;
    logic              run;
    logic              step;
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              eng_req;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_wdata;
    logic              eng_done;

    logic              host_gnt, eng_start, eng_gnt, ram_we, disp_bank, busy;
    logic [ADDR_W:0]   ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [GEN_W-1:0]  gen_count;

    logic              n_host_gnt, n_eng_start, n_eng_gnt, n_ram_we, n_disp_bank, n_busy;
    logic [ADDR_W:0]   n_ram_addr;
    logic [DATA_W-1:0] n_ram_wdata;
    logic [GEN_WN-1:0] n_gen_count;

    int tests_run;
    int tests_failed;
    int n_starts;
    int s0;
    logic exp_h;

    automata_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GEN_W(GEN_W)) u_dut (
        .clk108(clk108), .reset(reset), .frame_done(frame_done), .run(run), .step(step),
        .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .eng_start(eng_start), .eng_req(eng_req), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_gnt(eng_gnt), .eng_done(eng_done), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .disp_bank(disp_bank), .gen_count(gen_count), .busy(busy)
    );

    // Narrow generation counter instance so the wrap can be reached in a short run.
    automata_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GEN_W(GEN_WN)) u_dut_n (
        .clk108(clk108), .reset(reset), .frame_done(frame_done), .run(run), .step(step),
        .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(n_host_gnt),
        .eng_start(n_eng_start), .eng_req(eng_req), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_gnt(n_eng_gnt), .eng_done(eng_done), .ram_we(n_ram_we), .ram_addr(n_ram_addr),
        .ram_wdata(n_ram_wdata), .disp_bank(n_disp_bank), .gen_count(n_gen_count), .busy(n_busy)
    );

    initial clk108 = 1'b0;
    always #5 clk108 = ~clk108;

    always @(negedge clk108) begin
        if (eng_start === 1'b1) n_starts = n_starts + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk108);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; n_starts = 0;
        reset = 1'b1; frame_done = 1'b0; run = 1'b0; step = 1'b0; eng_done = 1'b0;
        host_req = 1'b0; host_addr = '0; host_wdata = '0;
        eng_req = 1'b0; eng_addr = '0; eng_wdata = '0;
        cyc(3);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_bank", disp_bank, 0);
        check("rst_gen", gen_count, 0);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_start", eng_start, 0);
        reset = 1'b0;
        cyc(2);

        // Single step: one start, one swap, back to idle
        s0 = n_starts;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        check("step_start", eng_start, 1);
        check("step_busy", busy, 1);
        cyc(9);
        eng_done = 1'b1;
        cyc(1);
        eng_done = 1'b0;
        check("step_wait_bank", disp_bank, 0);
        cyc(4);
        frame_done = 1'b1;
        cyc(1);
        frame_done = 1'b0;
        check("step_bank", disp_bank, 1);
        check("step_gen", gen_count, 1);
        check("step_idle", busy, 0);
        check("step_nstart", n_starts - s0, 1);

        // Continuous run for three generations, run dropped during the third
        do_reset();
        s0 = n_starts;
        run = 1'b1;
        cyc(1);
        for (int g = 0; g < 3; g++) begin
            cyc(3);
            if (g == 2) run = 1'b0;
            eng_done = 1'b1;
            cyc(1);
            eng_done = 1'b0;
            cyc(2);
            frame_done = 1'b1;
            cyc(1);
            frame_done = 1'b0;
        end
        cyc(2);
        check("run_nstart", n_starts - s0, 3);
        check("run_gen", gen_count, 3);
        check("run_bank", disp_bank, 1);
        check("run_idle", busy, 0);

        // Reset mid-generation abandons it; no start afterwards
        step = 1'b1; host_req = 1'b1; host_addr = 16'h0005; host_wdata = 20'h00007;
        cyc(1);
        step = 1'b0; host_req = 1'b0;
        check("rg_pre_start", eng_start, 1);
        check("rg_pre_we", ram_we, 1);
        reset = 1'b1;
        #1;
        check("rg_busy", busy, 0);
        check("rg_start", eng_start, 0);
        check("rg_bank", disp_bank, 0);
        check("rg_gen", gen_count, 0);
        check("rg_we", ram_we, 0);
        check("rg_addr", ram_addr, 0);
        check("rg_wdata", ram_wdata, 0);
        cyc(2);
        reset = 1'b0;
        s0 = n_starts;
        cyc(5);
        check("rg_nostart", n_starts - s0, 0);
        check("rg_idle", busy, 0);

        // eng_done in IDLE ignored; frame_done in GEN ignored; eng_done+frame_done same cycle no swap
        eng_done = 1'b1;
        cyc(1);
        eng_done = 1'b0;
        check("idle_done_busy", busy, 0);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        frame_done = 1'b1;
        cyc(1);
        frame_done = 1'b0;
        check("gen_fd_bank", disp_bank, 0);
        check("gen_fd_busy", busy, 1);
        s0 = n_starts;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(1);
        check("gen_step_ign", n_starts - s0, 0);
        eng_done = 1'b1; frame_done = 1'b1;
        cyc(1);
        eng_done = 1'b0; frame_done = 1'b0;
        check("same_bank", disp_bank, 0);
        check("same_gen", gen_count, 0);
        check("same_busy", busy, 1);
        cyc(2);
        frame_done = 1'b1;
        cyc(1);
        frame_done = 1'b0;
        check("next_bank", disp_bank, 1);
        check("next_gen", gen_count, 1);

        // Host write in the swap cycle targets the pre-swap bank
        do_reset();
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        eng_done = 1'b1;
        cyc(1);
        eng_done = 1'b0;
        host_req = 1'b1; host_addr = 16'h0ABC; host_wdata = 20'h12345; frame_done = 1'b1;
        #1;
        check("swap_hgnt", host_gnt, 1);
        cyc(1);
        host_req = 1'b0; frame_done = 1'b0;
        check("swap_addr", ram_addr, 32'h00ABC);
        check("swap_bank", disp_bank, 1);

        // Conflicting requests for four cycles in GEN
        do_reset();
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        for (int i = 0; i < 4; i++) begin
            host_req = 1'b1; eng_req = 1'b1;
            host_addr = 16'h0100 + 16'(i); eng_addr = 16'h0200 + 16'(i);
            host_wdata = 20'hA0000 + 20'(i); eng_wdata = 20'h50000 + 20'(i);
`ifdef AUTOMATA_SCHED_RR_EN
            exp_h = (i % 2 == 0);
`else
            exp_h = 1'b1;
`endif
            #1;
            check("arb_hgnt", host_gnt, exp_h);
            check("arb_egnt", eng_gnt, !exp_h);
            cyc(1);
            check("arb_we", ram_we, 1);
            check("arb_addr", ram_addr, exp_h ? {15'd0, 1'b0, 16'h0100 + 16'(i)} : {15'd0, 1'b1, 16'h0200 + 16'(i)});
            check("arb_wdata", ram_wdata, exp_h ? 32'hA0000 + i : 32'h50000 + i);
        end
        host_req = 1'b0;
        #1;
        check("eng_only_gnt", eng_gnt, 1);
        eng_req = 1'b0;
        cyc(1);
        cyc(1);
        check("nogrant_we", ram_we, 0);

        // Engine request outside GEN is never granted
        do_reset();
        eng_req = 1'b1;
        #1;
        check("idle_egnt", eng_gnt, 0);
        cyc(1);
        check("idle_we", ram_we, 0);
        eng_req = 1'b0;

        // Generation counter wrap (narrow instance wraps at 64)
        do_reset();
        run = 1'b1; eng_done = 1'b1; frame_done = 1'b1;
        cyc(127);
        check("wrap_pre_n", n_gen_count, 63);
        cyc(2);
        check("wrap_n", n_gen_count, 0);
        check("wrap_wide", gen_count, 64);
        run = 1'b0; eng_done = 1'b0; frame_done = 1'b0;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
